// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with a small write FIFO and per-frame runtime
// configuration (bit divisor, data width, parity, stop bits).
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | line high, waiting for a FIFO entry
// S_START  | start bit (0) for one bit period
// S_DATA   | data bits, LSB first, one bit period each
// S_PARITY | optional parity bit for one bit period
// S_STOP   | stop bit(s) high for one or two bit periods
module uart_tx_cfg #(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int MAX_DATA_BITS = 9,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [15:0]                  cfg_div,
  input  logic [3:0]                   cfg_data_bits,
  input  logic [1:0]                   cfg_parity,
  input  logic                         cfg_stop2,
  input  logic                         s_valid,
  input  logic [MAX_DATA_BITS-1:0]     s_data,
  output logic                         s_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         tx_serial,
  output logic                         tx_busy,
  output logic                         tx_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] MAX_BITS = 4'(MAX_DATA_BITS);

  if (CLK_FREQ <= 0 || MAX_DATA_BITS < 5 || MAX_DATA_BITS > 9 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_tx_cfg: illegal parameter value");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t state_q, state_d;

  logic [MAX_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]            count_q;
  logic                     push, pop, fifo_empty;

  logic [15:0]              eff_div;
  logic [3:0]               eff_bits;
  logic                     eff_par_en, eff_par_odd;

  logic [15:0]              div_q, div_d;
  logic [3:0]               nbits_q, nbits_d;
  logic                     par_en_q, par_en_d;
  logic                     par_odd_q, par_odd_d;
  logic                     stop2_q, stop2_d;
  logic [MAX_DATA_BITS-1:0] shift_q, shift_d;
  logic                     par_q, par_d;
  logic [3:0]               bit_cnt_q, bit_cnt_d;
  logic [16:0]              tmr_q, tmr_d;
  logic                     serial_q, serial_d;
  logic                     done_q, done_d;
  logic                     busy_q;
  logic                     begin_frame;

  assign fifo_empty = (count_q == '0);
  assign s_ready    = (count_q != CW'(FIFO_DEPTH));
  assign push       = s_valid && s_ready;
  assign fifo_count = count_q;
  assign tx_serial  = serial_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;

  // Effective configuration values, sampled only at frame start.
  always_comb begin
    eff_div = (cfg_div < 16'd2) ? 16'd2 : cfg_div;
    if (cfg_data_bits < 4'd5)
      eff_bits = 4'd5;
    else if (cfg_data_bits > MAX_BITS)
      eff_bits = MAX_BITS;
    else
      eff_bits = cfg_data_bits;
    eff_par_en  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
    eff_par_odd = (cfg_parity == 2'b10);
  end

  // FIFO storage; the array itself needs no reset since count_q gates reads.
  always_ff @(posedge clk) begin
    if (!rst && push)
      mem[wr_ptr_q] <= s_data;
  end

  // Next-state and datapath for the transmit FSM; bit timer counts down to 0.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    nbits_d     = nbits_q;
    par_en_d    = par_en_q;
    par_odd_d   = par_odd_q;
    stop2_d     = stop2_q;
    shift_d     = shift_q;
    par_d       = par_q;
    bit_cnt_d   = bit_cnt_q;
    tmr_d       = tmr_q;
    serial_d    = serial_q;
    done_d      = 1'b0;
    pop         = 1'b0;
    begin_frame = 1'b0;

    case (state_q)
      S_IDLE: begin
        serial_d = 1'b1;
        if (!fifo_empty)
          begin_frame = 1'b1;
      end
      S_START: begin
        if (tmr_q == '0) begin
          state_d   = S_DATA;
          serial_d  = shift_q[0];
          par_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = nbits_q - 4'd1;
          tmr_d     = {1'b0, div_q} - 17'd1;
        end else begin
          tmr_d = tmr_q - 17'd1;
        end
      end
      S_DATA: begin
        if (tmr_q == '0) begin
          if (bit_cnt_q != '0) begin
            serial_d  = shift_q[0];
            par_d     = par_q ^ shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q - 4'd1;
            tmr_d     = {1'b0, div_q} - 17'd1;
          end else if (par_en_q) begin
            state_d  = S_PARITY;
            serial_d = par_q ^ par_odd_q;
            tmr_d    = {1'b0, div_q} - 17'd1;
          end else begin
            state_d  = S_STOP;
            serial_d = 1'b1;
            tmr_d    = stop2_q ? ({div_q, 1'b0} - 17'd1) : ({1'b0, div_q} - 17'd1);
          end
        end else begin
          tmr_d = tmr_q - 17'd1;
        end
      end
      S_PARITY: begin
        if (tmr_q == '0) begin
          state_d  = S_STOP;
          serial_d = 1'b1;
          tmr_d    = stop2_q ? ({div_q, 1'b0} - 17'd1) : ({1'b0, div_q} - 17'd1);
        end else begin
          tmr_d = tmr_q - 17'd1;
        end
      end
      S_STOP: begin
        if (tmr_q == '0) begin
          done_d   = 1'b1;
          serial_d = 1'b1;
          state_d  = S_IDLE;
          if (!fifo_empty)
            begin_frame = 1'b1;
        end else begin
          tmr_d = tmr_q - 17'd1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        serial_d = 1'b1;
      end
    endcase

    // Frame start is shared by IDLE and back-to-back STOP exits.
    if (begin_frame) begin
      pop       = 1'b1;
      state_d   = S_START;
      serial_d  = 1'b0;
      shift_d   = mem[rd_ptr_q];
      div_d     = eff_div;
      nbits_d   = eff_bits;
      par_en_d  = eff_par_en;
      par_odd_d = eff_par_odd;
      stop2_d   = cfg_stop2;
      bit_cnt_d = '0;
      par_d     = 1'b0;
      tmr_d     = {1'b0, eff_div} - 17'd1;
    end
  end

  // State, FIFO pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      div_q     <= '0;
      nbits_q   <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      bit_cnt_q <= '0;
      tmr_q     <= '0;
      serial_q  <= 1'b1;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (push)
        wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q   <= count_q + CW'(push) - CW'(pop);
      div_q     <= div_d;
      nbits_q   <= nbits_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      stop2_q   <= stop2_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      bit_cnt_q <= bit_cnt_d;
      tmr_q     <= tmr_d;
      serial_q  <= serial_d;
      done_q    <= done_d;
      busy_q    <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: per-frame waveform compare against
// hand-built bit sequences, FIFO back-pressure and mid-frame reset.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg_div;
  logic [3:0]  cfg_data_bits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic        s_valid;
  logic [8:0]  s_data;
  logic        s_ready;
  logic [3:0]  fifo_count;
  logic        tx_serial;
  logic        tx_busy;
  logic        tx_done;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_cfg #(
    .CLK_FREQ(100_000_000),
    .MAX_DATA_BITS(9),
    .FIFO_DEPTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_div(cfg_div),
    .cfg_data_bits(cfg_data_bits),
    .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .fifo_count(fifo_count),
    .tx_serial(tx_serial),
    .tx_busy(tx_busy),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // seq holds line levels per bit period, index 0 = start bit.
  task automatic check_frame(input string tag, input logic [8:0] wdata, input logic [15:0] seq,
                             input int nbits, input int div, input int chg_at,
                             input logic [15:0] chg_div);
    logic [63:0] obs;
    logic [63:0] exp;
    logic        done_mid;
    int          len;
    len      = nbits * div;
    obs      = '0;
    exp      = '0;
    done_mid = 1'b0;
    for (int i = 0; i < len; i++) exp[i] = seq[i / div];
    s_valid = 1'b1;
    s_data  = wdata;
    tick();
    s_valid = 1'b0;
    check({tag, " idle_at_write"}, tx_serial, 1);
    for (int i = 0; i < len; i++) begin
      tick();
      obs[i]   = tx_serial;
      done_mid = done_mid | tx_done;
      if (i == 0) check({tag, " busy_at_start"}, tx_busy, 1);
      if (i == chg_at) cfg_div = chg_div;
    end
    check({tag, " wave"}, obs, exp);
    check({tag, " no_early_done"}, done_mid, 0);
    tick();
    check({tag, " done_pulse"}, tx_done, 1);
    check({tag, " idle_after"}, tx_serial, 1);
    check({tag, " busy_after"}, tx_busy, 0);
    tick();
    check({tag, " done_one_cycle"}, tx_done, 0);
  endtask

  logic [8:0] words [10];
  logic       ser [160];
  logic       dn  [160];

  initial begin
    logic [4:0] dw;
    int         ndone;
    logic       done_seen, low_seen;

    rst = 1'b1; s_valid = 1'b0; s_data = '0;
    cfg_div = 16'd4; cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    tick();
    tick();
    check("rst serial", tx_serial, 1);
    check("rst busy", tx_busy, 0);
    check("rst done", tx_done, 0);
    check("rst count", fifo_count, 0);
    check("rst ready", s_ready, 1);
    rst = 1'b0;
    tick();

    check_frame("f_a5", 9'h0A5, {1'b1, 8'hA5, 1'b0}, 10, 4, -1, 16'd0);

    cfg_div = 16'd3; cfg_data_bits = 4'd7; cfg_parity = 2'b01; cfg_stop2 = 1'b1;
    check_frame("f_03", 9'h003, {2'b11, 1'b0, 7'h03, 1'b0}, 11, 3, -1, 16'd0);

    cfg_div = 16'd0; cfg_data_bits = 4'd3; cfg_parity = 2'b10; cfg_stop2 = 1'b0;
    check_frame("f_1f", 9'h1FF, {1'b1, 1'b0, 5'h1F, 1'b0}, 8, 2, -1, 16'd0);

    cfg_div = 16'd1; cfg_data_bits = 4'd15; cfg_parity = 2'b01; cfg_stop2 = 1'b0;
    check_frame("f_155", 9'h155, {1'b1, 1'b1, 9'h155, 1'b0}, 12, 2, -1, 16'd0);

    cfg_div = 16'd2; cfg_data_bits = 4'd8; cfg_parity = 2'b11; cfg_stop2 = 1'b0;
    check_frame("f_3c_chg", 9'h03C, {1'b1, 8'h3C, 1'b0}, 10, 2, 5, 16'd5);
    check_frame("f_81_new", 9'h081, {1'b1, 8'h81, 1'b0}, 10, 5, -1, 16'd0);

    // Back-to-back FIFO fill: 5 data bits, div 2 -> 14-clock frames.
    cfg_div = 16'd2; cfg_data_bits = 4'd5; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    words[0] = 9'h011; words[1] = 9'h00A; words[2] = 9'h01F; words[3] = 9'h000;
    words[4] = 9'h015; words[5] = 9'h0E3; words[6] = 9'h01C; words[7] = 9'h007;
    words[8] = 9'h012; words[9] = 9'h01E;
    s_valid = 1'b1;
    s_data  = words[0];
    for (int c = 0; c < 150; c++) begin
      tick();
      ser[c] = tx_serial;
      dn[c]  = tx_done;
      if (c == 0) check("fifo count_first", fifo_count, 1);
      if (c == 1) check("fifo count_push_pop", fifo_count, 1);
      if (c == 8) begin
        check("fifo count_full", fifo_count, 8);
        check("fifo ready_full", s_ready, 0);
      end
      if (c == 9) check("fifo drop_when_full", fifo_count, 8);
      if (c < 9) begin
        s_valid = 1'b1;
        s_data  = words[c + 1];
      end else begin
        s_valid = 1'b0;
      end
    end
    ndone = 0;
    for (int c = 0; c < 150; c++) ndone += int'(dn[c]);
    check("fifo done_count", ndone, 9);
    for (int f = 0; f < 9; f++) begin
      for (int b = 0; b < 5; b++) dw[b] = ser[1 + 14 * f + 2 * (b + 1)];
      check($sformatf("fifo_word%0d", f), {ser[1 + 14 * f + 12], dw, ser[1 + 14 * f]},
            {1'b1, words[f][4:0], 1'b0});
      check($sformatf("fifo_done%0d", f), dn[15 + 14 * f], 1);
      if (f < 8) check($sformatf("fifo_contig%0d", f), ser[15 + 14 * f], 0);
    end
    check("fifo idle_end", ser[127], 1);

    // Mid-frame reset with three words queued.
    cfg_div = 16'd4; cfg_data_bits = 4'd8; cfg_parity = 2'b00;
    s_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_data = 9'h0AA + 9'(k);
      tick();
    end
    s_valid = 1'b0;
    check("rstmid queued", fifo_count, 3);
    tick(); tick(); tick();
    check("rstmid busy_pre", tx_busy, 1);
    check("rstmid serial_pre", tx_serial, 0);
    rst     = 1'b1;
    s_valid = 1'b1;
    s_data  = 9'h055;
    tick();
    check("rstmid serial", tx_serial, 1);
    check("rstmid busy", tx_busy, 0);
    check("rstmid count", fifo_count, 0);
    check("rstmid done", tx_done, 0);
    rst     = 1'b0;
    s_valid = 1'b0;
    done_seen = 1'b0;
    low_seen  = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      done_seen = done_seen | tx_done;
      low_seen  = low_seen | ~tx_serial;
    end
    check("rstmid no_done", done_seen, 0);
    check("rstmid line_idle", low_seen, 0);
    check("rstmid count_after", fifo_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
